// File: rtl/mycpu_pkg.sv
// rtl/mycpu_pkg.sv - shared types and constants for the CPU I/O controller
package mycpu_pkg;

    typedef enum logic [1:0] {
        IO_IDLE = 2'd0,
        IO_REQ  = 2'd1,
        IO_REL  = 2'd2,
        IO_DONE = 2'd3
    } io_state_t;

    localparam int IO_TIMEOUT_DEFAULT = 255;

    // The handshake is "open" while waiting for ack to rise or to fall again.
    function automatic logic io_in_handshake(input io_state_t s);
        return (s == IO_REQ) || (s == IO_REL);
    endfunction

endpackage

// File: rtl/io_timer.sv
// rtl/io_timer.sv - handshake watchdog counter with enable, clear and terminal count
module io_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);

    localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // tc fires during the LIMIT-th enabled cycle so the owner leaves on that edge.
    assign tc_o = en_i && (count_q == CW'(LIMIT - 1));

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/io_ctrl.sv
// rtl/io_ctrl.sv - 4-phase peripheral handshake controller; IO_TIMEOUT_EN adds a watchdog
module io_ctrl
    import mycpu_pkg::*;
#(
    parameter int DW             = 16,
    parameter int AW             = 8,
    parameter int TIMEOUT_CYCLES = IO_TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_in,
    input  logic          wen_in,
    input  logic [DW-1:0] addr_in,
    input  logic [DW-1:0] wdata_in,
    output logic          busy_out,
    output logic          done_out,
    output logic [DW-1:0] rdata_out,
    output logic          err_out,
    output logic          io_req_out,
    output logic          io_we_out,
    output logic [AW-1:0] io_addr_out,
    output logic [DW-1:0] io_wdata_out,
    input  logic          io_ack_in,
    input  logic [DW-1:0] io_rdata_in
);

    io_state_t     state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          we_q, we_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          timeout_hit;
    logic          accept;

    assign accept = (state_q == IO_IDLE) && start_in;

    generate
        if (AW < DW) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^addr_in[DW-1:AW];
        end
    endgenerate

`ifdef IO_TIMEOUT_EN
    logic err_q, err_d;

    io_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_io_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (io_in_handshake(state_q)),
        .clr_i (!io_in_handshake(state_q)),
        .tc_o  (timeout_hit)
    );

    always_comb begin
        err_d = err_q;
        if (accept) begin
            err_d = 1'b0;
        end else if (timeout_hit && !(state_q == IO_REQ && io_ack_in)
                     && !(state_q == IO_REL && !io_ack_in)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_out = err_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
    assign err_out     = 1'b0;
`endif

    // A real handshake step always wins over a watchdog expiring in the same cycle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        case (state_q)
            IO_IDLE: begin
                if (start_in) begin
                    state_d = IO_REQ;
                    addr_d  = addr_in[AW-1:0];
                    wdata_d = wdata_in;
                    we_d    = ~wen_in;
                end
            end
            IO_REQ: begin
                if (io_ack_in) begin
                    state_d = IO_REL;
                    if (!we_q) begin
                        rdata_d = io_rdata_in;
                    end
                end else if (timeout_hit) begin
                    state_d = IO_DONE;
                    rdata_d = '1;
                end
            end
            IO_REL: begin
                if (!io_ack_in) begin
                    state_d = IO_DONE;
                end else if (timeout_hit) begin
                    state_d = IO_DONE;
                    rdata_d = '1;
                end
            end
            IO_DONE: begin
                state_d = IO_IDLE;
            end
            default: begin
                state_d = IO_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IO_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

    assign busy_out     = (state_q != IO_IDLE);
    assign done_out     = (state_q == IO_DONE);
    assign io_req_out   = (state_q == IO_REQ);
    assign io_we_out    = we_q;
    assign io_addr_out  = addr_q;
    assign io_wdata_out = wdata_q;
    assign rdata_out    = rdata_q;

endmodule

// File: tb/tb_io_ctrl.sv
// tb/tb_io_ctrl.sv - randomized self-checking bench for io_ctrl (optionally with IO_TIMEOUT_EN)
module tb_io_ctrl;

    localparam int DW  = 16;
    localparam int AW  = 8;
    localparam int TMO = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_in = 1'b0;
    logic          wen_in = 1'b0;
    logic [DW-1:0] addr_in = '0;
    logic [DW-1:0] wdata_in = '0;
    logic          busy_out;
    logic          done_out;
    logic [DW-1:0] rdata_out;
    logic          err_out;
    logic          io_req_out;
    logic          io_we_out;
    logic [AW-1:0] io_addr_out;
    logic [DW-1:0] io_wdata_out;
    logic          io_ack_in = 1'b0;
    logic [DW-1:0] io_rdata_in = '0;

    int checks = 0;
    int errors = 0;

    // Reference model: the value rdata_out should hold between transactions.
    logic [DW-1:0] exp_rdata = '0;

    io_ctrl #(.DW(DW), .AW(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_in     (start_in),
        .wen_in       (wen_in),
        .addr_in      (addr_in),
        .wdata_in     (wdata_in),
        .busy_out     (busy_out),
        .done_out     (done_out),
        .rdata_out    (rdata_out),
        .err_out      (err_out),
        .io_req_out   (io_req_out),
        .io_we_out    (io_we_out),
        .io_addr_out  (io_addr_out),
        .io_wdata_out (io_wdata_out),
        .io_ack_in    (io_ack_in),
        .io_rdata_in  (io_rdata_in)
    );

    always #5 clk = ~clk;

    // ack_k: REQ cycle on which ack is high (1 = already high at REQ entry, 0 = never).
    // rel_h: REL cycles with ack still high before it drops.
    task automatic run_txn(input logic wen, input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [DW-1:0] rdata, input int ack_k, input int rel_h,
                           input bit noisy, input bit exp_timeout, input string name);
        int busy_cnt = 0;
        int done_cnt = 0;
        int req_cnt = 0;
        int rel_cnt = 0;
        int cyc = 0;
        int exp_busy;
        bit raised = 0;
        bit unstable = 0;
        bit seen_done = 0;
        logic [DW-1:0] rd_at_done = '0;
        logic err_at_done = 1'b0;

        start_in = 1'b1; wen_in = wen; addr_in = addr; wdata_in = wdata;
        if (ack_k == 1) begin
            io_ack_in = 1'b1; io_rdata_in = rdata; raised = 1;
        end
        if (exp_timeout) exp_rdata = '1;
        else if (wen) exp_rdata = rdata;
        exp_busy = exp_timeout ? TMO + 1 : ack_k + rel_h + 2;

        while (!seen_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start_in = noisy;
            if (noisy) begin
                wen_in = 1'($urandom); addr_in = 16'($urandom); wdata_in = 16'($urandom);
            end
            if (busy_out) busy_cnt++;
            if (busy_out && (io_addr_out !== addr[AW-1:0] || io_we_out !== ~wen || io_wdata_out !== wdata))
                unstable = 1;
            if (done_out) begin
                done_cnt++; seen_done = 1; rd_at_done = rdata_out; err_at_done = err_out;
            end
            if (io_req_out) begin
                req_cnt++;
                if (!raised && ack_k != 0 && req_cnt == ack_k) begin
                    io_ack_in = 1'b1; io_rdata_in = rdata; raised = 1;
                end else if (!raised) begin
                    io_rdata_in = 16'($urandom);
                end
            end else if (busy_out && !done_out && raised) begin
                rel_cnt++;
                if (rel_cnt > rel_h) begin
                    io_ack_in = 1'b0; io_rdata_in = 16'($urandom);
                end
            end
        end
        start_in = 1'b0;
        io_ack_in = 1'b0;
        @(negedge clk);
        if (done_out) done_cnt++;

        checks++;
        if (!seen_done) begin errors++; $display("FAIL %s done_seen actual=0 required=1", name); end
        checks++;
        if (busy_cnt != exp_busy) begin errors++; $display("FAIL %s busy_cycles actual=%0d required=%0d", name, busy_cnt, exp_busy); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL %s done_pulses actual=%0d required=1", name, done_cnt); end
        checks++;
        if (unstable) begin errors++; $display("FAIL %s req_fields_stable actual=0 required=1", name); end
        checks++;
        if (rd_at_done !== exp_rdata) begin errors++; $display("FAIL %s rdata_at_done actual=%h required=%h", name, rd_at_done, exp_rdata); end
        checks++;
        if (err_at_done !== exp_timeout) begin errors++; $display("FAIL %s err_at_done actual=%b required=%b", name, err_at_done, exp_timeout); end
        checks++;
        if (busy_out !== 1'b0 || io_req_out !== 1'b0 || rdata_out !== exp_rdata) begin
            errors++;
            $display("FAIL %s after_done busy=%b req=%b rdata=%h required busy=0 req=0 rdata=%h", name, busy_out, io_req_out, rdata_out, exp_rdata);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({busy_out, done_out, rdata_out, err_out, io_req_out, io_we_out, io_addr_out, io_wdata_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b done=%b rdata=%h err=%b req=%b we=%b addr=%h wdata=%h required all 0",
                     busy_out, done_out, rdata_out, err_out, io_req_out, io_we_out, io_addr_out, io_wdata_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ior();
        run_txn(1'b1, 16'h0034, 16'h5A5A, 16'hBEEF, 3, 1, 1'b0, 1'b0, "ior");
        checks++;
        if (io_addr_out !== 8'h34 || io_we_out !== 1'b0) begin
            errors++; $display("FAIL ior_fields addr=%h we=%b required addr=34 we=0", io_addr_out, io_we_out);
        end
    endtask

    task automatic test_iow();
        run_txn(1'b0, 16'h00A7, 16'h1234, 16'hDEAD, 1, 0, 1'b0, 1'b0, "iow_best_case");
        checks++;
        if (io_we_out !== 1'b1 || io_wdata_out !== 16'h1234) begin
            errors++; $display("FAIL iow_fields we=%b wdata=%h required we=1 wdata=1234", io_we_out, io_wdata_out);
        end
    endtask

    task automatic test_busy_start_stray_ack();
        bit bad = 0;
        run_txn(1'b1, 16'h0011, 16'h0000, 16'h7E57, 2, 2, 1'b1, 1'b0, "start_while_busy");
        io_ack_in = 1'b1;
        io_rdata_in = 16'hC0DE;
        repeat (3) begin
            @(negedge clk);
            if (busy_out !== 1'b0 || io_req_out !== 1'b0 || done_out !== 1'b0 || rdata_out !== exp_rdata) bad = 1;
        end
        io_ack_in = 1'b0;
        checks++;
        if (bad) begin errors++; $display("FAIL stray_ack_idle reacted actual=1 required=0"); end
    endtask

    task automatic test_reset_in_rel();
        bit saw_done = 0;
        run_txn(1'b1, 16'h0042, 16'h0000, 16'hA5C3, 1, 0, 1'b0, 1'b0, "pre_reset_read");
        start_in = 1'b1; wen_in = 1'b1; addr_in = 16'h0099; wdata_in = 16'h0;
        io_ack_in = 1'b1; io_rdata_in = 16'h1111;
        @(negedge clk);
        start_in = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_out !== 1'b1 || io_req_out !== 1'b0) begin
            errors++; $display("FAIL reach_rel busy=%b req=%b required busy=1 req=0", busy_out, io_req_out);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_out, done_out, rdata_out, err_out, io_req_out, io_we_out, io_addr_out, io_wdata_out} !== '0) begin
            errors++;
            $display("FAIL async_reset_rel busy=%b done=%b rdata=%h err=%b req=%b we=%b addr=%h wdata=%h required all 0",
                     busy_out, done_out, rdata_out, err_out, io_req_out, io_we_out, io_addr_out, io_wdata_out);
        end
        exp_rdata = '0;
        io_ack_in = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done_out) saw_done = 1;
        end
        rst_n = 1'b1;
        checks++;
        if (saw_done) begin errors++; $display("FAIL reset_no_done actual=1 required=0"); end
        run_txn(1'b1, 16'h0077, 16'h0000, 16'h4321, 2, 0, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_timeout();
`ifdef IO_TIMEOUT_EN
        run_txn(1'b1, 16'h0055, 16'h0000, 16'h0000, 0, 0, 1'b0, 1'b1, "timeout");
        run_txn(1'b0, 16'h0056, 16'hFACE, 16'h0000, 2, 1, 1'b0, 1'b0, "err_cleared");
`else
        bit bad = 0;
        start_in = 1'b1; wen_in = 1'b1; addr_in = 16'h0055;
        @(negedge clk);
        start_in = 1'b0;
        repeat (60) begin
            if (busy_out !== 1'b1 || io_req_out !== 1'b1 || done_out !== 1'b0 || err_out !== 1'b0) bad = 1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin errors++; $display("FAIL no_timeout_wait left_req actual=1 required=0"); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_rdata = '0;
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            run_txn(1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
                    1'($urandom), 1'b0, $sformatf("random_%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_ior();
        test_iow();
        test_busy_start_stray_ack();
        test_reset_in_rel();
        test_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_ctrl.md
IO_CTRL -- requirements
Module: io_ctrl

Interface
REQ-001 Parameter DW, default 16: CPU data width.
REQ-002 Parameter AW, default 8: peripheral address width, taken from addr_in[AW-1:0].
REQ-003 Parameter TIMEOUT_CYCLES, default 255: maximum wait for io_ack_in, in clk cycles; used only with IO_TIMEOUT_EN.
REQ-004 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-005 Port rst_n, input, 1: reset; asynchronous, active-low.
REQ-006 Port start_in, input, 1: one-cycle pulse from the CU in EX0 when iom=1.
REQ-007 Port wen_in, input, 1: CU wen; 0 = IOW (write), 1 = IOR (read).
REQ-008 Port addr_in, input, DW: I/O address from the register file.
REQ-009 Port wdata_in, input, DW: IOW data.
REQ-010 Port busy_out, output, 1: transaction in progress; the CU stalls while it is high.
REQ-011 Port done_out, output, 1: one-cycle completion pulse.
REQ-012 Port rdata_out, output, DW: IOR result, valid from the done_out cycle until the next start.
REQ-013 Port err_out, output, 1: the last transaction timed out.
REQ-014 Port io_req_out, output, 1: 4-phase request to the peripheral.
REQ-015 Port io_we_out, output, 1: 1 = write.
REQ-016 Port io_addr_out, output, AW: peripheral address.
REQ-017 Port io_wdata_out, output, DW: peripheral write data.
REQ-018 Port io_ack_in, input, 1: peripheral acknowledge.
REQ-019 Port io_rdata_in, input, DW: peripheral read data; sampled when io_ack_in rises.

Function
REQ-020 The FSM SHALL have states IO_IDLE, IO_REQ, IO_REL and IO_DONE.
REQ-021 IO_IDLE with start_in=1 SHALL move to IO_REQ, latching addr_in[AW-1:0], wdata_in and ~wen_in into io_addr_out, io_wdata_out and io_we_out.
REQ-022 In IO_REQ, io_req_out SHALL be 1.
- Exit to IO_REL on the first cycle io_ack_in=1.
- In that same cycle, latch io_rdata_in into rdata_out on a read; on a write, rdata_out holds its value.
REQ-023 In IO_REL, io_req_out SHALL be 0.
- Remain until io_ack_in=0, then go to IO_DONE.
REQ-024 IO_DONE SHALL last exactly one cycle with done_out=1, then return to IO_IDLE.
REQ-025 busy_out SHALL be 1 in IO_REQ, IO_REL and IO_DONE, and 0 in IO_IDLE.
REQ-026 Best-case latency SHALL be 4 cycles: start -> REQ, ack -> REL, ack low -> DONE, DONE -> IDLE.
REQ-027 start_in outside IO_IDLE SHALL be ignored.
REQ-028 io_ack_in=1 while in IO_IDLE SHALL be ignored.
REQ-029 An ack already high on REQ entry SHALL be accepted on the first REQ cycle.
REQ-030 io_addr_out, io_we_out and io_wdata_out SHALL stay stable from REQ entry until IO_DONE.
REQ-031 err_out SHALL be cleared on each accepted start.

Reset
REQ-032 On rst_n=0, immediately and independent of clk, the block SHALL:
- enter IO_IDLE;
- drive every output to 0, including rdata_out, err_out and io_req_out;
- clear the timeout counter.
REQ-033 Reset during a transaction SHALL abort it with no done_out pulse; the first legal start is on the first clk edge with rst_n=1.

Configuration
REQ-034 With IO_TIMEOUT_EN defined, a counter SHALL count cycles spent in IO_REQ or IO_REL.
- When the count reaches TIMEOUT_CYCLES, go to IO_DONE with err_out=1, drop io_req_out, and set rdata_out to all ones.
REQ-035 Without IO_TIMEOUT_EN, there SHALL be no counter logic, err_out SHALL be tied to 0, and the FSM SHALL wait indefinitely.

Structure
REQ-036 The io_state_t enum (IO_IDLE, IO_REQ, IO_REL, IO_DONE) and the IO_TIMEOUT_DEFAULT constant SHALL live in mycpu_pkg.
REQ-037 The timeout counter SHALL be the sub-module io_timer (enable, clear, terminal-count output), instantiated only under IO_TIMEOUT_EN.

Verification
REQ-038 IOR: start with wen=1 and addr 16'h0034; peripheral acks on the 3rd REQ cycle with rdata 16'hBEEF -> io_addr_out=8'h34, io_we_out=0, rdata_out=16'hBEEF, one done_out pulse, err_out=0.
REQ-039 IOW: start with wen=0 and wdata 16'h1234; peripheral acks immediately -> io_we_out=1, io_wdata_out=16'h1234 stable until DONE, 4-cycle total latency.
REQ-040 Start while busy, plus a stray ack in IDLE -> no second request, no state change.
REQ-041 rst_n low while in IO_REL -> all outputs 0 asynchronously, no done_out, and a clean new transaction is possible afterwards.
REQ-042 IO_TIMEOUT_EN with TIMEOUT_CYCLES=10 and no ack -> DONE after 10 cycles, err_out=1, rdata_out=16'hFFFF; without the macro the block stays busy.
